// File: rtl/control_panel.sv
// rtl/control_panel.sv - front-panel button conditioning, edit-mode FSM and select registers
module control_panel #(
    parameter int         DEBOUNCE_CYCLES = 480,
    parameter int         HOLD_CYCLES     = 24000,
    parameter int         REPEAT_CYCLES   = 9600,
    parameter logic [2:0] FREQ_INIT       = 3'd4,
    parameter logic [2:0] LP_INIT         = 3'd1,
    parameter logic [2:0] HP_INIT         = 3'd3
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] freq_select,
    output logic [2:0] lowpass_select,
    output logic [2:0] highpass_select,
    output logic [1:0] edit_mode,
    output logic [2:0] edit_value,
    output logic       change_pulse
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HR_W   = $clog2(HR_MAX + 1);

    typedef enum logic [1:0] {
        ST_FREQ = 2'd0,
        ST_LP   = 2'd1,
        ST_HP   = 2'd2
    } state_t;

    // Button index: 0 = mode, 1 = up, 2 = down.
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    state_t          state_q, state_d;
    logic [2:0]      freq_q, freq_d;
    logic [2:0]      lp_q, lp_d;
    logic [2:0]      hp_q, hp_d;
    logic            change_q, change_d;

    logic [HR_W-1:0] hold_q, hold_d;
    logic            run_q, run_d;
    logic            rep_q, rep_d;
    logic            conflict_q, conflict_d;

    logic [2:0]      press;
    logic            mode_ev, up_ev, dn_ev;
    logic            up_lvl, dn_lvl;
    logic            step_ok, rpt_fire;
    logic            step_up, step_dn;
    logic [2:0]      nxt_val;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press   = deb_q & ~deb_prev_q;
    assign mode_ev = press[0];
    assign up_ev   = press[1];
    assign dn_ev   = press[2];
    assign up_lvl  = deb_q[1];
    assign dn_lvl  = deb_q[2];

    // Steps only while exactly one direction is held, no unresolved conflict, and no mode event this cycle.
    assign step_ok = (up_lvl ^ dn_lvl) & ~conflict_q & ~mode_ev;

    always_comb begin
        conflict_d = conflict_q;
        if (up_lvl && dn_lvl) begin
            conflict_d = 1'b1;
        end else if (!up_lvl && !dn_lvl) begin
            conflict_d = 1'b0;
        end

        hold_d   = hold_q;
        run_d    = run_q;
        rep_d    = rep_q;
        rpt_fire = 1'b0;
        if (!step_ok) begin
            hold_d = '0;
            run_d  = 1'b0;
            rep_d  = 1'b0;
        end else if (up_ev || dn_ev) begin
            hold_d = HR_W'(1);
            run_d  = 1'b1;
            rep_d  = 1'b0;
        end else if (run_q) begin
            if ((!rep_q && hold_q == HR_W'(HOLD_CYCLES)) ||
                ( rep_q && hold_q == HR_W'(REPEAT_CYCLES))) begin
                rpt_fire = 1'b1;
                rep_d    = 1'b1;
                hold_d   = HR_W'(1);
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign step_up = step_ok & up_lvl & (up_ev | rpt_fire);
    assign step_dn = step_ok & dn_lvl & (dn_ev | rpt_fire);

    always_comb begin
        case (state_q)
            ST_LP:   edit_value = lp_q;
            ST_HP:   edit_value = hp_q;
            default: edit_value = freq_q;
        endcase
    end

    always_comb begin
        nxt_val = edit_value;
        if (step_up && edit_value != 3'd7) begin
            nxt_val = edit_value + 3'd1;
        end else if (step_dn && edit_value != 3'd0) begin
            nxt_val = edit_value - 3'd1;
        end

        change_d = (nxt_val != edit_value);
        freq_d   = freq_q;
        lp_d     = lp_q;
        hp_d     = hp_q;
        case (state_q)
            ST_LP:   lp_d   = nxt_val;
            ST_HP:   hp_d   = nxt_val;
            default: freq_d = nxt_val;
        endcase

        state_d = state_q;
        if (mode_ev) begin
            case (state_q)
                ST_FREQ: state_d = ST_LP;
                ST_LP:   state_d = ST_HP;
                default: state_d = ST_FREQ;
            endcase
        end
    end

    always_ff @(posedge clk_48) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q    <= ST_FREQ;
            freq_q     <= FREQ_INIT;
            lp_q       <= LP_INIT;
            hp_q       <= HP_INIT;
            change_q   <= 1'b0;
            hold_q     <= '0;
            run_q      <= 1'b0;
            rep_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= {btn_down, btn_up, btn_mode};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q    <= state_d;
            freq_q     <= freq_d;
            lp_q       <= lp_d;
            hp_q       <= hp_d;
            change_q   <= change_d;
            hold_q     <= hold_d;
            run_q      <= run_d;
            rep_q      <= rep_d;
            conflict_q <= conflict_d;
        end
    end

    assign freq_select     = freq_q;
    assign lowpass_select  = lp_q;
    assign highpass_select = hp_q;
    assign edit_mode       = state_q;
    assign change_pulse    = change_q;

endmodule

// File: tb/tb_control_panel.sv
// tb/tb_control_panel.sv - directed vector bench for control_panel
module tb_control_panel;

    logic       clk_48 = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] freq_select, lowpass_select, highpass_select, edit_value;
    logic [1:0] edit_mode;
    logic       change_pulse;

    int n_vec = 0;
    int n_bad = 0;
    int pulses = 0;

    control_panel #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (5),
        .FREQ_INIT      (3'd4),
        .LP_INIT        (3'd1),
        .HP_INIT        (3'd3)
    ) dut (
        .clk_48         (clk_48),
        .reset_n        (reset_n),
        .btn_mode       (btn_mode),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .freq_select    (freq_select),
        .lowpass_select (lowpass_select),
        .highpass_select(highpass_select),
        .edit_mode      (edit_mode),
        .edit_value     (edit_value),
        .change_pulse   (change_pulse)
    );

    always #5 clk_48 = ~clk_48;

    typedef struct {
        logic m, u, d;
        int   n;
        int   f, lp, hp, em, ev, p;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic m, logic u, logic d, int n,
                                int f, int lp, int hp, int em, int ev, int p);
        vec_t v;
        v.m = m; v.u = u; v.d = d; v.n = n;
        v.f = f; v.lp = lp; v.hp = hp; v.em = em; v.ev = ev; v.p = p;
        return v;
    endfunction

    task automatic run(int n);
        pulses = 0;
        repeat (n) begin
            @(posedge clk_48);
            @(negedge clk_48);
            if (change_pulse) pulses++;
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int f, int lp, int hp, int em, int ev, int p);
        chk({tag, " freq"}, int'(freq_select), f);
        chk({tag, " lp"}, int'(lowpass_select), lp);
        chk({tag, " hp"}, int'(highpass_select), hp);
        chk({tag, " edit_mode"}, int'(edit_mode), em);
        chk({tag, " edit_value"}, int'(edit_value), ev);
        chk({tag, " pulses"}, pulses, p);
    endtask

    initial begin
        // m u d  n   f lp hp em ev p
        tbl.push_back(mk(0, 1, 0,  6, 4, 1, 3, 0, 4, 0));
        tbl.push_back(mk(0, 1, 0,  1, 5, 1, 3, 0, 5, 1));
        tbl.push_back(mk(0, 1, 0,  3, 5, 1, 3, 0, 5, 0));
        tbl.push_back(mk(0, 0, 0, 10, 5, 1, 3, 0, 5, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(0, 1, 0, 3, 5, 1, 3, 0, 5, 0));
            tbl.push_back(mk(0, 0, 0, 3, 5, 1, 3, 0, 5, 0));
        end
        tbl.push_back(mk(0, 0, 0,  4, 5, 1, 3, 0, 5, 0));
        tbl.push_back(mk(1, 0, 0,  7, 5, 1, 3, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 3, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0,  7, 5, 1, 3, 2, 3, 0));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 3, 2, 3, 0));
        tbl.push_back(mk(0, 0, 1,  7, 5, 1, 2, 2, 2, 1));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 2, 2, 2, 0));
        tbl.push_back(mk(0, 0, 1,  7, 5, 1, 1, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 1, 2, 1, 0));
        tbl.push_back(mk(0, 0, 1,  7, 5, 1, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1,  7, 5, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0,  7, 5, 1, 0, 0, 5, 0));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 0, 0, 5, 0));
        tbl.push_back(mk(1, 0, 0,  7, 5, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0,  8, 5, 1, 0, 1, 1, 0));
        // Auto-repeat in LOWPASS: press step, then +20, then every +5 until saturation.
        tbl.push_back(mk(0, 1, 0,  7, 5, 2, 0, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 20, 5, 3, 0, 1, 3, 1));
        tbl.push_back(mk(0, 1, 0,  5, 5, 4, 0, 1, 4, 1));
        tbl.push_back(mk(0, 1, 0,  5, 5, 5, 0, 1, 5, 1));
        tbl.push_back(mk(0, 1, 0,  5, 5, 6, 0, 1, 6, 1));
        tbl.push_back(mk(0, 1, 0,  5, 5, 7, 0, 1, 7, 1));
        tbl.push_back(mk(0, 1, 0, 13, 5, 7, 0, 1, 7, 0));
        tbl.push_back(mk(0, 0, 0, 10, 5, 7, 0, 1, 7, 0));
        // Conflicts: both held, then down alone stays suppressed until both released.
        tbl.push_back(mk(0, 0, 1,  7, 5, 6, 0, 1, 6, 1));
        tbl.push_back(mk(0, 1, 1, 30, 5, 6, 0, 1, 6, 0));
        tbl.push_back(mk(0, 0, 1, 30, 5, 6, 0, 1, 6, 0));
        tbl.push_back(mk(0, 0, 0, 10, 5, 6, 0, 1, 6, 0));
        tbl.push_back(mk(1, 1, 0,  7, 5, 6, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 10, 5, 6, 0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 0,  7, 5, 6, 0, 0, 5, 0));
        tbl.push_back(mk(0, 0, 0,  8, 5, 6, 0, 0, 5, 0));
        tbl.push_back(mk(0, 1, 0, 30, 7, 6, 0, 0, 7, 2));

        reset_n = 1'b0;
        run(3);
        chk_all("reset", 4, 1, 3, 0, 4, 0);
        reset_n = 1'b1;
        run(1);
        chk_all("post_reset", 4, 1, 3, 0, 4, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            btn_mode = tbl[i].m;
            btn_up   = tbl[i].u;
            btn_down = tbl[i].d;
            run(tbl[i].n);
            chk_all($sformatf("v%0d", i), tbl[i].f, tbl[i].lp, tbl[i].hp,
                    tbl[i].em, tbl[i].ev, tbl[i].p);
        end

        // Reset while up is held and repeating, then a fresh press after release.
        reset_n = 1'b0;
        run(3);
        chk_all("held_reset", 4, 1, 3, 0, 4, 0);
        reset_n = 1'b1;
        run(6);
        chk_all("held_release_6", 4, 1, 3, 0, 4, 0);
        run(1);
        chk_all("held_release_7", 5, 1, 3, 0, 5, 1);
        run(1);
        chk_all("held_release_8", 5, 1, 3, 0, 5, 0);

        btn_up = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/control_panel.md
# control_panel

Front-panel control block for the channel strip. It takes three raw push-buttons (mode, up, down) and synchronises and debounces them. It then drives the three 3-bit selection buses consumed by the sine generator, lowpass and highpass stages. This is the producer side of the select interface those stages read. It also reports which parameter is being edited and its current value, so the display path can show it.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 480: consecutive stable samples needed before a debounced level changes (10 ms at 48 kHz).
- HOLD_CYCLES, 24000: cycles an up/down button must stay held before auto-repeat starts.
- REPEAT_CYCLES, 9600: cycles between auto-repeat steps once repeating.
- FREQ_INIT, 4: reset value of freq_select.
- LP_INIT, 1: reset value of lowpass_select.
- HP_INIT, 3: reset value of highpass_select.

Ports:
- clk_48  in  1  sample-rate clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- btn_mode  in  1  raw mode button, asynchronous, active-high.
- btn_up  in  1  raw increment button, asynchronous, active-high.
- btn_down  in  1  raw decrement button, asynchronous, active-high.
- freq_select  out  3  sine generator frequency select.
- lowpass_select  out  3  lowpass filter select.
- highpass_select  out  3  highpass filter select.
- edit_mode  out  2  parameter under edit: 0 = FREQ, 1 = LOWPASS, 2 = HIGHPASS; 3 is never driven.
- edit_value  out  3  current value of the selected parameter (combinational mux of registered values).
- change_pulse  out  1  one-cycle strobe on any select change.

## Operation

- **Input conditioning.** Each button has its own 2-flop synchroniser (sync1, sync2) and its own debouncer.
- **Debouncer.** Holds a debounced level and a counter.
  - While sync2 equals the debounced level, the counter is 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync2 still differing, the debounced level flips on that edge and the counter clears.
  - Any sample matching the debounced level clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- **Press events.** A press event is a rising edge of a debounced level (debounced high, previous debounced low). Releases generate no event.
- **Mode FSM.** States FREQ → LOWPASS → HIGHPASS → FREQ.
  - Advances one state per mode press event.
  - edit_mode encodes the state.
  - A mode event also cancels any auto-repeat in progress.
- **Step logic.** Applies only to the parameter selected by the current state.
  - An up event adds 1, saturating at 7.
  - A down event subtracts 1, saturating at 0.
  - A step that saturates leaves the value unchanged and does not assert change_pulse.
- **Auto-repeat.** Runs per direction while exactly one of up/down is debounced-high.
  - A hold counter counts from the press event.
  - The first repeat step is taken HOLD_CYCLES cycles after the press event.
  - Further steps follow every REPEAT_CYCLES cycles until release.
  - Release, a mode event, or the other direction going high clears the hold counter.
- **Simultaneous events.**
  - up and down debounced-high together: no steps, and repeat is suppressed until both are released.
  - A mode event and an up/down event on the same cycle: the mode change wins and the step is discarded.
- **Unselected parameters.** They hold their values.

## Timing

- **Reset.** Any edge with reset_n = 0 clears all synchronisers, debouncers, counters and the FSM. Outputs after reset:
  - freq_select = FREQ_INIT, lowpass_select = LP_INIT, highpass_select = HP_INIT.
  - edit_mode = 0, edit_value = FREQ_INIT, change_pulse = 0.
- **Mid-operation reset.** Reset asserted while a button is held or repeat is active discards everything. After release of reset, a still-held button needs a full synchronise + debounce period and then produces a fresh press event.
- **Latency.** Raw input high, first sampled at edge 0:
  - sync2 is high after edge 1.
  - The debounced level flips at edge DEBOUNCE_CYCLES+1.
  - The select register and change_pulse update at edge DEBOUNCE_CYCLES+2.
  - edit_mode updates on that same edge for a mode press.
- **Outputs.**
  - change_pulse is high exactly one cycle, aligned with the select register update.
  - The select outputs are registered and are stable between changes.

## Test plan

Benches use DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 20, REPEAT_CYCLES = 5.

- **Reset values:** hold reset_n low 3 cycles, then release → freq/lp/hp = 4/1/3, edit_mode = 0, edit_value = 4, change_pulse = 0.
- **Single press:** btn_up high for 10 cycles in FREQ mode → freq_select becomes 5 exactly 6 edges after the first sample, one change_pulse, lp/hp unchanged.
- **Glitch rejection:** btn_up pulses of 3 cycles high / 3 low, repeated → no change at all.
  - Then two mode presses followed by down ×4 → edit_mode = 2, highpass_select goes 3→0, with a fourth press producing no pulse.
- **Auto-repeat:** hold btn_up 60 cycles in LOWPASS with value 1 → one step at the press, then repeats at +20 and every +5 after that, saturating at 7. change_pulse count equals number of actual increments (6).
- **Conflicts:** up and down held together → no change.
  - Mode and up debounced on the same cycle → edit_mode advances, no value change.
- **Reset while held:** reset asserted while up is repeating → values return to init.
  - After reset release with up still held → a single step after 6 edges.
